seq_detect_prog: RTL and testbench

//  Programmable serial bit-pattern detector. Runtime pattern, length 1..MAX_LEN, overlap/non-overlap mode.

---
 rtl/seq_detect_prog.sv | 159 +++++++++++++++
 tb/tb_seq_detect_prog.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
// -----------------------------------------------------------------------------
// seq_detect_prog
//   Programmable serial bit-pattern detector. The pattern (1..MAX_LEN bits),
//   its length and the overlap mode are loaded at run time. Input bits are
//   valid-qualified. A registered one-cycle match pulse is produced one clock
//   after the completing bit, and a saturating counter tallies match pulses.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset (config returns to DEF_*)
//   cfg_load     load cfg_pattern / cfg_len / cfg_overlap this cycle
//   cfg_pattern  new pattern, right-aligned; bit [len-1] is received first
//   cfg_len      new length, legal range 1..MAX_LEN
//   cfg_overlap  new mode: 1 = overlapping, 0 = non-overlapping
//   cfg_err      1-cycle pulse: a cfg_load was rejected (illegal cfg_len)
//   in_valid     in_bit is valid this cycle
//   in_bit       serial data bit
//   clr_count    clear match_count (wins over a simultaneous match pulse)
//   match        1-cycle pulse: pattern completed
//   match_count  saturating count of match pulses
// -----------------------------------------------------------------------------
module seq_detect_prog #(
  parameter int unsigned          MAX_LEN     = 8,
  parameter int unsigned          LEN_W       = 4,
  parameter int unsigned          CNT_W       = 8,
  parameter logic [MAX_LEN-1:0]   DEF_PATTERN = 8'h0A,
  parameter int unsigned          DEF_LEN     = 4,
  parameter logic                 DEF_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               clr_count,
  output logic               match,
  output logic [CNT_W-1:0]   match_count
);

  typedef enum logic [0:0] {
    HUNT  = 1'b0,
    ARMED = 1'b1
  } state_e;

  // Configuration registers
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q,     len_d;
  logic               overlap_q, overlap_d;

  // Datapath / FSM registers
  logic [MAX_LEN-1:0] hist_q,    hist_d;
  logic [LEN_W-1:0]   fill_q,    fill_d;
  state_e             state_q,   state_d;
  logic               match_q,   match_d;
  logic               cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0]   count_q,   count_d;

  // Combinational helpers
  logic [MAX_LEN-1:0] len_mask;
  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic               cfg_len_ok;
  logic               hit;

  // Mask selecting the low len_q bits of hist/pattern.
  always_comb begin
    len_mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
  end

  always_comb begin
    cfg_len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    hist_shift = {hist_q[MAX_LEN-2:0], in_bit};
    // ARMED means fill already equals len, so it saturates there.
    fill_inc   = (state_q == ARMED) ? len_q : fill_q + LEN_W'(1);
    hit        = (fill_inc == len_q) &&
                 ((hist_shift & len_mask) == (pattern_q & len_mask));
  end

  // Next-state / output logic
  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    state_d   = state_q;
    match_d   = 1'b0;
    cfg_err_d = 1'b0;

    if (cfg_load && cfg_len_ok) begin
      // Accepted load: restart detection; a same-cycle input bit is dropped.
      pattern_d = cfg_pattern;
      len_d     = cfg_len;
      overlap_d = cfg_overlap;
      fill_d    = '0;
      state_d   = HUNT;
    end else begin
      // A rejected load only flags the error; data processing continues.
      cfg_err_d = cfg_load;
      if (in_valid) begin
        hist_d  = hist_shift;
        match_d = hit;
        if (hit && !overlap_q) begin
          fill_d  = '0;
          state_d = HUNT;
        end else begin
          fill_d  = fill_inc;
          state_d = (fill_inc == len_q) ? ARMED : HUNT;
        end
      end
    end
  end

  // Saturating match counter; clear has priority.
  always_comb begin
    count_d = count_q;
    if (clr_count) begin
      count_d = '0;
    end else if (match_q && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q <= DEF_PATTERN;
      len_q     <= LEN_W'(DEF_LEN);
      overlap_q <= DEF_OVERLAP;
      hist_q    <= '0;
      fill_q    <= '0;
      state_q   <= HUNT;
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      count_q   <= '0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      state_q   <= state_d;
      match_q   <= match_d;
      cfg_err_q <= cfg_err_d;
      count_q   <= count_d;
    end
  end

  assign match       = match_q;
  assign cfg_err     = cfg_err_q;
  assign match_count = count_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
module tb_seq_detect_prog;

  logic       clk;
  logic       reset;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       in_valid;
  logic       in_bit;
  logic       clr_count;

  logic       match,  cfg_err;
  logic [7:0] match_count;
  logic       match2, cfg_err2;
  logic [1:0] match_count2;

  int compared = 0;
  int failed   = 0;

  seq_detect_prog dut (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_bit(in_bit), .clr_count(clr_count),
    .match(match), .match_count(match_count)
  );

  seq_detect_prog #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err2),
    .in_valid(in_valid), .in_bit(in_bit), .clr_count(clr_count),
    .match(match2), .match_count(match_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       ld;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ov;
    logic       v;
    logic       b;
    logic       clr;
    logic       d2;   // 1: check the CNT_W=2 instance
    logic       em;
    logic       ee;
    logic [7:0] ec;
    logic       cc;   // 1: check the count
  } vec_t;

  vec_t tbl [0:79];
  int   n = 0;

  task automatic add(input logic rst, input logic ld, input logic [7:0] pat,
                     input logic [3:0] len, input logic ov, input logic v,
                     input logic b, input logic clr, input logic d2,
                     input logic em, input logic ee, input logic [7:0] ec,
                     input logic cc);
    tbl[n] = '{rst, ld, pat, len, ov, v, b, clr, d2, em, ee, ec, cc};
    n++;
  endtask

  // Shorthands: valid bit, idle cycle, clear, load
  task automatic vb(input logic b, input logic em, input logic [7:0] ec, input logic d2);
    add(0, 0, 8'h00, 4'd0, 0, 1, b, 0, d2, em, 0, ec, 1);
  endtask
  task automatic idle(input logic [7:0] ec, input logic d2);
    add(0, 0, 8'h00, 4'd0, 0, 0, 0, 0, d2, 0, 0, ec, 1);
  endtask
  task automatic clr(input logic d2);
    add(0, 0, 8'h00, 4'd0, 0, 0, 0, 1, d2, 0, 0, 8'd0, 1);
  endtask
  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                      input logic d2);
    add(0, 1, pat, len, ov, 0, 0, 0, d2, 0, 0, 8'd0, 1);
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s step %0d: got %0d want %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ld, input logic [7:0] pat,
                       input logic [3:0] len, input logic ov, input logic v,
                       input logic b, input logic c);
    @(negedge clk);
    reset = rst; cfg_load = ld; cfg_pattern = pat; cfg_len = len;
    cfg_overlap = ov; in_valid = v; in_bit = b; clr_count = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; in_valid = 1'b0; in_bit = 1'b0; clr_count = 1'b0;

    // Reset state
    add(1, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0, 0, 8'd0, 1);
    add(1, 0, 8'h00, 4'd0, 0, 0, 0, 0, 1, 0, 0, 8'd0, 1);

    // T1: default 1010 overlapping, stream 1,0,1,0,1,0,0
    vb(1, 0, 0, 0); vb(0, 0, 0, 0); vb(1, 0, 0, 0); vb(0, 1, 0, 0);
    vb(1, 0, 1, 0); vb(0, 1, 1, 0); vb(0, 0, 2, 0);
    idle(2, 0); clr(0);

    // T2: 1010 non-overlapping
    load(8'h0A, 4'd4, 0, 0);
    vb(1, 0, 0, 0); vb(0, 0, 0, 0); vb(1, 0, 0, 0); vb(0, 1, 0, 0);
    vb(1, 0, 1, 0); vb(0, 0, 1, 0); vb(0, 0, 1, 0);
    clr(0);

    // T3: 110 len 3 with idle gaps
    load(8'h06, 4'd3, 1, 0);
    vb(1, 0, 0, 0); idle(0, 0); vb(1, 0, 0, 0); idle(0, 0);
    vb(0, 1, 0, 0); idle(1, 0); clr(0);

    // T4: legal load drops same-cycle bit; illegal loads flag error, bits kept
    add(0, 1, 8'h0A, 4'd4, 1, 1, 1, 0, 0, 0, 0, 8'd0, 1);
    add(0, 1, 8'hFF, 4'd0, 0, 1, 0, 0, 0, 0, 1, 8'd0, 1);
    add(0, 1, 8'hFF, 4'd9, 0, 1, 1, 0, 0, 0, 1, 8'd0, 1);
    vb(0, 0, 0, 0); vb(1, 0, 0, 0); vb(0, 1, 0, 0);
    idle(1, 0); clr(0);

    // T6: partial match aborted by reset; config back to default
    load(8'h06, 4'd3, 1, 0);
    vb(1, 0, 0, 0); vb(0, 0, 0, 0); vb(1, 0, 0, 0);
    add(1, 0, 8'h00, 4'd0, 0, 1, 0, 0, 0, 0, 0, 8'd0, 1);
    vb(0, 0, 0, 0);
    vb(1, 0, 0, 0); vb(0, 0, 0, 0); vb(1, 0, 0, 0); vb(0, 1, 0, 0);
    idle(1, 0);

    // T5: CNT_W=2 instance, len 1 pattern 1, saturation and clear-on-match
    clr(1);
    load(8'h01, 4'd1, 1, 1);
    vb(1, 1, 0, 1); vb(1, 1, 1, 1); vb(1, 1, 2, 1); vb(1, 1, 3, 1); vb(1, 1, 3, 1);
    add(0, 0, 8'h00, 4'd0, 0, 1, 1, 1, 1, 1, 0, 8'd0, 1);
    vb(0, 0, 1, 1);

    for (int i = 0; i < n; i++) begin
      drive(tbl[i].rst, tbl[i].ld, tbl[i].pat, tbl[i].len, tbl[i].ov,
            tbl[i].v, tbl[i].b, tbl[i].clr);
      if (tbl[i].d2) begin
        chk("match2", i, {7'd0, match2}, {7'd0, tbl[i].em});
        chk("cfg_err2", i, {7'd0, cfg_err2}, {7'd0, tbl[i].ee});
        if (tbl[i].cc) chk("count2", i, {6'd0, match_count2}, tbl[i].ec);
      end else begin
        chk("match", i, {7'd0, match}, {7'd0, tbl[i].em});
        chk("cfg_err", i, {7'd0, cfg_err}, {7'd0, tbl[i].ee});
        if (tbl[i].cc) chk("count", i, match_count, tbl[i].ec);
      end
    end

    // Hand-written: long idle gap inside a 1010 match, then a single pulse
    drive(0, 1, 8'h0A, 4'd4, 1, 0, 0, 1);
    drive(0, 0, 8'h00, 4'd0, 0, 1, 1, 0);
    drive(0, 0, 8'h00, 4'd0, 0, 1, 0, 0);
    drive(0, 0, 8'h00, 4'd0, 0, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 8'h00, 4'd0, 0, 0, 0, 0);
      chk("gap_nomatch", k, {7'd0, match}, 8'd0);
    end
    drive(0, 0, 8'h00, 4'd0, 0, 1, 0, 0);
    chk("gap_match", 0, {7'd0, match}, 8'd1);
    drive(0, 0, 8'h00, 4'd0, 0, 0, 0, 0);
    chk("gap_pulse_end", 0, {7'd0, match}, 8'd0);
    chk("gap_count", 0, match_count, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
